// File: rtl/polar_info_extract.sv
// Polar information-bit extractor: ping-pong buffers two decoded blocks and streams out
// the non-frozen bits lowest index first. Define POLAR_INFO_EXTRACT_LAST_EN to add out_last.
module polar_info_extract #(
    parameter int N        = 4,
    parameter int IDX_BITS = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                u      [N],
    input  logic                frozen [N],
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_bit,
    output logic [IDX_BITS-1:0] out_idx,
`ifdef POLAR_INFO_EXTRACT_LAST_EN
    output logic                out_last,
`endif
    output logic                overflow
);

    logic [N-1:0]        slot_u   [2];
    logic [N-1:0]        slot_rem [2];
    logic                wr;
    logic                rd;
    logic [1:0]          count;

    logic [N-1:0]        in_u_vec;
    logic [N-1:0]        in_rem_vec;
    logic [N-1:0]        cur_rem;
    logic [N-1:0]        cur_u;
    logic [N-1:0]        clr_mask;
    logic [N-1:0]        rem_nxt;
    logic [IDX_BITS-1:0] sel_idx;
    logic                accept;
    logic                fire;
    logic                pop;

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        in_u_vec   = '0;
        in_rem_vec = '0;
        for (int i = 0; i < N; i++) begin
            in_u_vec[i]   = u[i];
            in_rem_vec[i] = ~frozen[i];
        end
    end

    always_comb begin
        cur_rem  = slot_rem[rd];
        cur_u    = slot_u[rd];
        sel_idx  = '0;
        // Scan downward so the lowest pending index wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (cur_rem[i]) sel_idx = IDX_BITS'(i);
        end
        out_valid = (count != 2'd0) && (|cur_rem);
        out_idx   = out_valid ? sel_idx : '0;
        out_bit   = out_valid ? cur_u[sel_idx] : 1'b0;
        fire      = out_valid && out_ready;
        clr_mask  = '0;
        if (fire) clr_mask[sel_idx] = 1'b1;
        rem_nxt   = cur_rem & ~clr_mask;
        // An all-frozen slot has rem_nxt==0 immediately and pops without output.
        pop       = (count != 2'd0) && (rem_nxt == '0);
        accept    = in_valid && (count != 2'd2);
    end

    assign in_ready = (count != 2'd2);

`ifdef POLAR_INFO_EXTRACT_LAST_EN
    assign out_last = out_valid && ((cur_rem & (cur_rem - N'(1))) == '0);
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr          <= 1'b0;
            rd          <= 1'b0;
            count       <= 2'd0;
            overflow    <= 1'b0;
            slot_rem[0] <= '0;
            slot_rem[1] <= '0;
        end else begin
            if (count != 2'd0) slot_rem[rd] <= rem_nxt;
            // With count<2 and count!=0, wr and rd point at different slots.
            if (accept) slot_rem[wr] <= in_rem_vec;
            if (accept) wr <= ~wr;
            if (pop)    rd <= ~rd;
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (in_valid && !accept) overflow <= 1'b1;
        end
    end

    // NOTE: the data store is not reset; rem and count already mark every slot empty.
    always_ff @(posedge clk) begin
        if (accept) slot_u[wr] <= in_u_vec;
    end

endmodule

// File: tb/tb_polar_info_extract.sv
// Directed self-checking bench for polar_info_extract (N=4); covers out_last when
// POLAR_INFO_EXTRACT_LAST_EN is defined.
module tb_polar_info_extract;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       u_in      [N];
    logic       frozen_in [N];
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_bit;
    logic [1:0] out_idx;
    logic       overflow;
`ifdef POLAR_INFO_EXTRACT_LAST_EN
    logic       out_last;
`endif

    int checks = 0;
    int passed = 0;

    polar_info_extract #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .u         (u_in),
        .frozen    (frozen_in),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_idx   (out_idx),
`ifdef POLAR_INFO_EXTRACT_LAST_EN
        .out_last  (out_last),
`endif
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed bit i maps to element i (element 0 is the first bit of the block).
    task automatic set_block(input logic [N-1:0] u_p, input logic [N-1:0] fz_p);
        for (int i = 0; i < N; i++) begin
            u_in[i]      = u_p[i];
            frozen_in[i] = fz_p[i];
        end
    endtask

    task automatic send(input logic [N-1:0] u_p, input logic [N-1:0] fz_p);
        set_block(u_p, fz_p);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_bit(input string tag, input logic [1:0] idx, input logic b);
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " idx"},   32'(out_idx),   32'(idx));
        check({tag, " bit"},   32'(out_bit),   32'(b));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, " valid"}, 32'(out_valid), 32'd0);
        check({tag, " idx"},   32'(out_idx),   32'd0);
        check({tag, " bit"},   32'(out_bit),   32'd0);
    endtask

    initial begin
        logic [N-1:0] pat;
        set_block('0, '0);
        #12;
        expect_idle("reset");
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
`ifdef POLAR_INFO_EXTRACT_LAST_EN
        check("reset last", 32'(out_last), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Basic drain: frozen={1,1,0,0}, u={0,0,1,0}
        out_ready = 1'b1;
        send(4'b0100, 4'b0011);
        expect_bit("basic0", 2'd2, 1'b1);
        tick();
        expect_bit("basic1", 2'd3, 1'b0);
        tick();
        expect_idle("basic end");
        check("basic in_ready", 32'(in_ready), 32'd1);

        // Backpressure: held stable for 5 stalled cycles
        out_ready = 1'b0;
        send(4'b0100, 4'b0011);
        for (int k = 0; k < 5; k++) begin
            expect_bit("stall", 2'd2, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        expect_bit("bp0", 2'd2, 1'b1);
        tick();
        expect_bit("bp1", 2'd3, 1'b0);
        tick();
        expect_idle("bp end");

        // Overflow: three back-to-back strobes with out_ready low
        out_ready = 1'b0;
        set_block(4'b0101, 4'b0000);
        in_valid = 1'b1;
        tick();
        check("ovf ready after 1", 32'(in_ready), 32'd1);
        set_block(4'b1010, 4'b0000);
        tick();
        check("ovf ready after 2", 32'(in_ready), 32'd0);
        check("ovf flag after 2", 32'(overflow), 32'd0);
        set_block(4'b1111, 4'b0000);
        tick();
        in_valid = 1'b0;
        check("ovf flag after 3", 32'(overflow), 32'd1);
        check("ovf ready after 3", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pat = (k < 4) ? 4'b0101 : 4'b1010;
            expect_bit("ovf drain", 2'(k % 4), pat[k % 4]);
            tick();
        end
        expect_idle("ovf end");
        check("ovf sticky", 32'(overflow), 32'd1);
        check("ovf end in_ready", 32'(in_ready), 32'd1);

        // All-frozen block A followed by block B on the next edge
        set_block(4'b1111, 4'b1111);
        in_valid = 1'b1;
        tick();
        check("frozen idle valid", 32'(out_valid), 32'd0);
        set_block(4'b0101, 4'b0000);
        tick();
        in_valid = 1'b0;
        pat = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            expect_bit("after frozen", 2'(k), pat[k]);
            tick();
        end
        expect_idle("after frozen end");

        // Reset mid-drain: u={1,1,0,1}
        send(4'b1011, 4'b0000);
        expect_bit("rst pre0", 2'd0, 1'b1);
        tick();
        expect_bit("rst pre1", 2'd1, 1'b1);
        rst_n = 1'b0;
        #1;
        expect_idle("in reset");
        check("in reset overflow", 32'(overflow), 32'd0);
        check("in reset in_ready", 32'(in_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        tick();
        send(4'b1110, 4'b0000);
        pat = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            expect_bit("post rst", 2'(k), pat[k]);
            tick();
        end
        expect_idle("post rst end");

`ifdef POLAR_INFO_EXTRACT_LAST_EN
        // frozen={0,1,0,1}, u={1,0,0,0}
        send(4'b0001, 4'b1010);
        expect_bit("last0", 2'd0, 1'b1);
        check("last0 flag", 32'(out_last), 32'd0);
        tick();
        expect_bit("last1", 2'd2, 1'b0);
        check("last1 flag", 32'(out_last), 32'd1);
        tick();
        check("last idle flag", 32'(out_last), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
